// File: rtl/cla_seq_adder_ctrl_pkg.sv
// rtl/cla_seq_adder_ctrl_pkg.sv - shared constants, FSM encoding and index sizing for cla_seq_adder_ctrl
package cla_seq_adder_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the nibble index counter; never narrower than one bit.
  function automatic int idx_width(input int nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

// File: rtl/cla_seq_adder_ctrl_cla4.sv
// rtl/cla_seq_adder_ctrl_cla4.sv - 4-bit carry-lookahead adder slice
module cla_seq_adder_ctrl_cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  // Generate/propagate lookahead: every carry is a flat function of g, p and ci.
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    s    = p ^ c;
  end

endmodule

// File: rtl/cla_seq_adder_ctrl.sv
// rtl/cla_seq_adder_ctrl.sv - nibble-serial wide adder around one CLA slice; CLA_SEQ_SUB_EN adds subtract via op
module cla_seq_adder_ctrl
  import cla_seq_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CLA_SEQ_SUB_EN
  input  logic             op,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NSLICE = WIDTH / NIBBLE_W;
  localparam int IDX_W  = idx_width(NSLICE);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);

  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic                carry;
  logic [WIDTH-1:0]    a_reg;
  logic [WIDTH-1:0]    b_reg;
`ifdef CLA_SEQ_SUB_EN
  logic                op_reg;
`endif

  int                  base;
  logic [NIBBLE_W-1:0] slice_a;
  logic [NIBBLE_W-1:0] slice_b;
  logic [NIBBLE_W-1:0] slice_s;
  logic                slice_co;

  // Accepting only in IDLE keeps operations strictly non-overlapping.
  assign in_ready = (state == IDLE) && !rst;

  // Select the current nibble of each latched operand for the shared slice.
  always_comb begin
    base    = int'(idx) * NIBBLE_W;
    slice_a = a_reg[base +: NIBBLE_W];
    slice_b = b_reg[base +: NIBBLE_W];
`ifdef CLA_SEQ_SUB_EN
    if (op_reg) slice_b = ~slice_b;
`endif
  end

  cla_seq_adder_ctrl_cla4 u_slice (
    .a  (slice_a),
    .b  (slice_b),
    .ci (carry),
    .s  (slice_s),
    .co (slice_co)
  );

  // Controller FSM: latch operands, walk nibbles LSB first, then hold the result until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
`ifdef CLA_SEQ_SUB_EN
      op_reg    <= 1'b0;
`endif
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= b;
`ifdef CLA_SEQ_SUB_EN
            op_reg <= op;
            // Subtraction is a + ~b + 1, so the incoming carry is forced to 1.
            carry  <= op ? 1'b1 : cin;
`else
            carry  <= cin;
`endif
            idx   <= '0;
            sum   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          sum[base +: NIBBLE_W] <= slice_s;
          carry <= slice_co;
          idx   <= idx + IDX_W'(1);
          if (idx == IDX_LAST) begin
            cout  <= slice_co;
            state <= DONE;
          end
        end
        DONE: begin
          // out_valid rises on the first DONE edge; the handshake only counts once it is visible.
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// tb/tb_cla_seq_adder_ctrl.sv - directed self-checking bench for cla_seq_adder_ctrl (define CLA_SEQ_SUB_EN for subtract tests)
module tb_cla_seq_adder_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        busy;

  int nvec;
  int nerr;

  cla_seq_adder_ctrl #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef CLA_SEQ_SUB_EN
    .op        (op),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands until accepted; returns positioned just after the acceptance edge.
  task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic c, output bit to);
    int n;
    to       = 1'b0;
    a        = av;
    b        = bv;
    cin      = c;
    in_valid = 1'b1;
    n        = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) to = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!out_valid && cnt < 20);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    nvec++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b, want 0 0 0", in_ready, out_valid, busy);
    end
    nvec++;
    if (sum !== 16'h0000 || cout !== 1'b0) begin
      nerr++;
      $display("FAIL reset_data: sum=%h cout=%b, want 0000 0", sum, cout);
    end
    rst = 1'b0;
    tick();
    nvec++;
    if (in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL reset_release: in_ready=%b, want 1", in_ready);
    end
  endtask

  task automatic test_carry_chain();
    bit to;
    int cnt;
    send(16'hFFFF, 16'h0001, 1'b0, to);
    nvec++;
    if (to) begin nerr++; $display("FAIL chain_accept: timeout=1, want 0"); end
    wait_valid(cnt);
    nvec++;
    if (cnt !== 5) begin
      nerr++;
      $display("FAIL chain_latency: %0d cycles, want 5", cnt);
    end
    nvec++;
    if (sum !== 16'h0000 || cout !== 1'b1) begin
      nerr++;
      $display("FAIL chain_result: sum=%h cout=%b, want 0000 1", sum, cout);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_busy();
    bit to;
    bit bad;
    int n;
    bad = 1'b0;
    send(16'h1234, 16'h4321, 1'b1, to);
    n = 0;
    while (!out_valid && n < 20) begin
      if (in_ready !== 1'b0 || busy !== 1'b1) bad = 1'b1;
      tick();
      n++;
    end
    if (in_ready !== 1'b0 || busy !== 1'b1) bad = 1'b1;
    nvec++;
    if (to || !out_valid) begin
      nerr++;
      $display("FAIL busy_timeout: to=%b out_valid=%b, want 0 1", to, out_valid);
    end
    nvec++;
    if (bad) begin
      nerr++;
      $display("FAIL busy_window: in_ready/busy deviated from 0/1 while active");
    end
    nvec++;
    if (sum !== 16'h5556 || cout !== 1'b0) begin
      nerr++;
      $display("FAIL busy_result: sum=%h cout=%b, want 5556 0", sum, cout);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    nvec++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL busy_release: in_ready=%b busy=%b out_valid=%b, want 1 0 0", in_ready, busy, out_valid);
    end
  endtask

  task automatic test_backpressure();
    bit to;
    bit bad;
    int cnt;
    bad = 1'b0;
    send(16'h4000, 16'h4000, 1'b0, to);
    wait_valid(cnt);
    nvec++;
    if (to || sum !== 16'h8000 || cout !== 1'b0) begin
      nerr++;
      $display("FAIL bp_result: to=%b sum=%h cout=%b, want 0 8000 0", to, sum, cout);
    end
    for (int i = 0; i < 10; i++) begin
      a        = 16'($urandom);
      b        = 16'($urandom);
      cin      = 1'($urandom);
      in_valid = 1'($urandom);
      tick();
      if (sum !== 16'h8000 || cout !== 1'b0 || out_valid !== 1'b1 || in_ready !== 1'b0) bad = 1'b1;
    end
    nvec++;
    if (bad) begin
      nerr++;
      $display("FAIL bp_hold: outputs changed under backpressure, now sum=%h cout=%b ov=%b ir=%b, want 8000 0 1 0",
               sum, cout, out_valid, in_ready);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    nvec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid_run();
    bit to;
    bit seen;
    int cnt;
    seen = 1'b0;
    send(16'h1111, 16'h2222, 1'b0, to);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nvec++;
    if (out_valid !== 1'b0 || sum !== 16'h0000 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL rst_run_clear: out_valid=%b sum=%h busy=%b, want 0 0000 0", out_valid, sum, busy);
    end
    tick();
    nvec++;
    if (in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL rst_run_ready: in_ready=%b, want 1", in_ready);
    end
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    nvec++;
    if (seen) begin
      nerr++;
      $display("FAIL rst_run_pulse: out_valid=1 seen after abandon, want 0");
    end
    send(16'h0F0F, 16'h00F1, 1'b0, to);
    wait_valid(cnt);
    nvec++;
    if (to || cnt !== 5 || sum !== 16'h1000 || cout !== 1'b0) begin
      nerr++;
      $display("FAIL rst_run_next: to=%b lat=%0d sum=%h cout=%b, want 0 5 1000 0", to, cnt, sum, cout);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int acc_t [2];
    logic [15:0] r_sum [2];
    logic        r_cout [2];
    int nacc;
    int nres;
    bit acc_now;
    bit res_now;
    nacc      = 0;
    nres      = 0;
    out_ready = 1'b1;
    a         = 16'hAAAA;
    b         = 16'h5555;
    cin       = 1'b1;
    in_valid  = 1'b1;
    for (int cyc = 0; cyc < 40 && nres < 2; cyc++) begin
      acc_now = in_valid && in_ready;
      res_now = out_valid && out_ready;
      if (res_now) begin
        r_sum[nres]  = sum;
        r_cout[nres] = cout;
      end
      tick();
      if (acc_now) begin
        acc_t[nacc] = cyc;
        nacc++;
        if (nacc == 1) begin
          a   = 16'h0001;
          b   = 16'h0001;
          cin = 1'b0;
        end else begin
          in_valid = 1'b0;
        end
      end
      if (res_now) nres++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    nvec++;
    if (nacc != 2 || nres != 2) begin
      nerr++;
      $display("FAIL b2b_count: accepts=%0d results=%0d, want 2 2", nacc, nres);
    end else begin
      nvec++;
      if (r_sum[0] !== 16'h0000 || r_cout[0] !== 1'b1) begin
        nerr++;
        $display("FAIL b2b_first: sum=%h cout=%b, want 0000 1", r_sum[0], r_cout[0]);
      end
      nvec++;
      if (r_sum[1] !== 16'h0002 || r_cout[1] !== 1'b0) begin
        nerr++;
        $display("FAIL b2b_second: sum=%h cout=%b, want 0002 0", r_sum[1], r_cout[1]);
      end
      nvec++;
      if (acc_t[1] - acc_t[0] < 6) begin
        nerr++;
        $display("FAIL b2b_gap: %0d cycles between accepts, want >= 6", acc_t[1] - acc_t[0]);
      end
    end
    tick();
  endtask

`ifdef CLA_SEQ_SUB_EN
  task automatic test_subtract();
    bit to;
    int cnt;
    op = 1'b1;
    send(16'h0005, 16'h0007, 1'b1, to);
    wait_valid(cnt);
    nvec++;
    if (to || sum !== 16'hFFFE || cout !== 1'b0) begin
      nerr++;
      $display("FAIL sub_borrow: to=%b sum=%h cout=%b, want 0 fffe 0", to, sum, cout);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    send(16'h0007, 16'h0005, 1'b0, to);
    wait_valid(cnt);
    nvec++;
    if (to || sum !== 16'h0002 || cout !== 1'b1) begin
      nerr++;
      $display("FAIL sub_noborrow: to=%b sum=%h cout=%b, want 0 0002 1", to, sum, cout);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    op = 1'b0;
  endtask
`endif

  initial begin
    nvec      = 0;
    nerr      = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    op        = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_carry_chain();
    test_busy();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
`ifdef CLA_SEQ_SUB_EN
    test_subtract();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/cla_seq_adder_ctrl.md
Name: cla_seq_adder_ctrl

Overview:
Sequencing controller that performs a WIDTH-bit addition by time-multiplexing one 4-bit carry-lookahead adder slice over WIDTH/4 nibbles, least significant nibble first.
The carry-out of each slice is registered and fed back as the carry-in of the next.
Valid/ready handshakes are used on both the operand side and the result side.
Used wherever a wide add is needed but area rules out a full-width lookahead chain.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 8.
- NSLICE, WIDTH/4, localparam (not overridable); number of nibble passes.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands a, b, cin are presented
- in_ready  output  1  controller can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry into the least significant nibble
- out_valid  output  1  sum/cout are valid
- out_ready  input  1  consumer accepts the result
- sum  output  WIDTH  registered result
- cout  output  1  registered final carry-out
- busy  output  1  high in RUN or DONE

Behaviour:
- Clocking: one clock (clk). Reset rst is synchronous and active-high.
- Reset values: state=IDLE, slice index=0, carry register=0, sum=0, cout=0, out_valid=0, busy=0.
  - in_ready = (state==IDLE) && !rst, so it is 0 while rst is high.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch a, b; carry register<=cin; index<=0; sum<=0; go to RUN.
- RUN, one nibble per cycle:
  - Slice inputs are a_reg[4*idx+:4], b_reg[4*idx+:4] and the carry register.
  - The slice sum nibble is written to sum[4*idx+:4].
  - Carry register <= slice carry-out.
  - idx <= idx+1.
  - When idx==NSLICE-1: cout <= slice carry-out, and go to DONE.
- DONE:
  - out_valid=1; sum and cout held stable.
  - On out_ready: out_valid<=0 and go to IDLE.
- Latency:
  - Operands are accepted at edge T.
  - out_valid is high from edge T+NSLICE+1, which is 5 cycles for WIDTH=16.
- Throughput: one result per NSLICE+2 cycles at most. There is no overlap: in_ready=0 in RUN and DONE.
- Changes on a/b/cin/in_valid while busy are ignored, because the operands are latched.
- Backpressure: out_ready held low keeps the block in DONE indefinitely, with outputs frozen.
- Reset mid-RUN or mid-DONE: the operation is abandoned and all outputs return to their reset values on that edge. There is no partial result and out_valid never pulses.
- Arithmetic is unsigned modulo 2^WIDTH, and cout is the true carry out of bit WIDTH-1.

Optional Feature:
Macro CLA_SEQ_SUB_EN.
- Defined:
  - Extra input port op (1 bit), sampled on acceptance; op=1 means subtract.
  - Subtract computes a-b as a + ~b + 1: b nibbles are inverted at the slice input, and the carry register is loaded with 1 (cin is ignored).
  - cout=1 means no borrow.
- Undefined:
  - The op port is absent; the block is add only.
  - There is no inversion logic.

Decomposition:
- Shared package/include holds:
  - NIBBLE_W=4.
  - FSM state encodings: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Widths of the index counter, derived via clog2 of NSLICE.
- One sub-module: the 4-bit carry-lookahead adder slice, the existing team lookahead cell, instantiated once.
- The controller contains only the FSM, operand/sum registers, the carry register and the nibble muxes.

Test Plan:
- WIDTH=16, a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1; out_valid rises exactly 5 cycles after the acceptance edge.
- a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0; in_ready=0 and busy=1 from acceptance until out_valid&&out_ready.
- Result 0x8000 held with out_ready=0 for 10 cycles, while a/b toggle randomly -> sum/cout stable, in_ready=0; one cycle of out_ready -> IDLE and in_ready=1 on the next cycle.
- rst pulsed for one cycle during RUN at idx=2 -> out_valid never asserts, sum=0, in_ready=1 the cycle after rst falls; the next transaction 0x0F0F+0x00F1 -> sum=0x1000, cout=0.
- Back-to-back: in_valid held high with out_ready tied high, operands (0xAAAA,0x5555,cin=1) then (0x0001,0x0001,cin=0) -> results 0x0000/cout=1 then 0x0002/cout=0, with at least NSLICE+2 cycles between acceptances.
- CLA_SEQ_SUB_EN defined, op=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0; a=0x0007, b=0x0005 -> sum=0x0002, cout=1.
